// File: rtl/pergate_am_fj_driver_pkg.sv
// Field definitions shared by the per-gate addmul/fj driver: element width,
// modulus and the single-subtract modular adder.
package pergate_am_fj_driver_pkg;

  localparam int unsigned F_NBITS = 16;
  localparam int unsigned NUM_FJ  = 3;

  typedef logic [F_NBITS-1:0] fe_t;

  localparam fe_t F_Q = 16'd65521;

  // Operands are always reduced, so one conditional subtract brings a+b back below q.
  function automatic fe_t field_modadd_f(input fe_t a, input fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) begin
      s = s - {1'b0, F_Q};
    end
    return s[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/pergate_am_fj_driver_if.sv
// Handshake bundle between the driver (master) and one per-gate compute unit (slave).
interface pergate_am_fj_driver_if;
  import pergate_am_fj_driver_pkg::*;

  logic      en_am;
  logic      restart;
  logic      gate_id_bit;
  logic      ready_pulse_am;
  logic      en_fj;
  logic      ready_fj;
  fe_t [2:0] fj;

  modport master (
    output en_am,
    output restart,
    output gate_id_bit,
    output en_fj,
    input  ready_pulse_am,
    input  ready_fj,
    input  fj
  );

  modport slave (
    input  en_am,
    input  restart,
    input  gate_id_bit,
    input  en_fj,
    output ready_pulse_am,
    output ready_fj,
    output fj
  );

endinterface

// File: rtl/pergate_am_fj_driver_modadd.sv
// Combinational a + b mod q for already-reduced field elements.
module field_modadd
  import pergate_am_fj_driver_pkg::*;
(
  input  fe_t a,
  input  fe_t b,
  output fe_t sum
);

  always_comb begin
    sum = field_modadd_f(a, b);
  end

endmodule

// File: rtl/pergate_am_fj_driver.sv
// Per-gate initiator: issues addmul then fj for each sumcheck round and folds
// the three fj products into running mod-q accumulators.
module pergate_am_fj_driver
  import pergate_am_fj_driver_pkg::*;
#(
  parameter int unsigned NROUNDS = 8,
  // Wide enough to hold NROUNDS itself, where the counter saturates.
  parameter int unsigned ID_BITS = $clog2(NROUNDS + 1)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [NROUNDS-1:0]  gate_id,
  input  logic                go,
  output logic                busy,
  output logic                round_done,
  output logic                all_done,
  output logic [ID_BITS-1:0]  round_idx,
  output fe_t [2:0]           acc,
  pergate_am_fj_driver_if.master unit
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AM_ISSUE,
    S_AM_WAIT,
    S_FJ_ISSUE,
    S_FJ_WAIT,
    S_ACC
  } state_t;

  localparam logic [ID_BITS-1:0] LAST_IDX = ID_BITS'(NROUNDS);

  state_t              state;
  state_t              state_nx;
  logic [NROUNDS-1:0]  gate_lat;
  fe_t [2:0]           cap;
  fe_t [2:0]           acc_sum;
  logic [ID_BITS-1:0]  next_idx;
  logic                cur_bit;
  logic                start;

  assign start    = go & ~all_done;
  assign next_idx = round_idx + ID_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_AM_ISSUE;
      S_AM_ISSUE: state_nx = S_AM_WAIT;
      S_AM_WAIT:  if (unit.ready_pulse_am) state_nx = S_FJ_ISSUE;
      S_FJ_ISSUE: state_nx = S_FJ_WAIT;
      S_FJ_WAIT:  if (unit.ready_fj) state_nx = S_ACC;
      S_ACC:      state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Round counter never exceeds NROUNDS-1 while issuing, so this mux always hits.
  always_comb begin
    cur_bit = 1'b0;
    for (int unsigned i = 0; i < NROUNDS; i++) begin
      if (round_idx == ID_BITS'(i)) cur_bit = gate_lat[i];
    end
  end

  always_comb begin
    unit.en_am       = 1'b0;
    unit.restart     = 1'b0;
    unit.gate_id_bit = 1'b0;
    unit.en_fj       = 1'b0;
    busy             = (state != S_IDLE);
    if (state == S_AM_ISSUE) begin
      unit.en_am       = 1'b1;
      unit.restart     = (round_idx == '0);
      unit.gate_id_bit = cur_bit;
    end
    if (state == S_FJ_ISSUE) begin
      unit.en_fj = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_FJ; k++) begin : g_add
    field_modadd u_add (
      .a   (acc[k]),
      .b   (cap[k]),
      .sum (acc_sum[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      gate_lat   <= '0;
      cap        <= '0;
      acc        <= '0;
      round_idx  <= '0;
      round_done <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      round_done <= (state == S_ACC);
      if (state == S_IDLE && start) begin
        gate_lat <= gate_id;
      end
      if (state == S_FJ_WAIT && unit.ready_fj) begin
        cap <= unit.fj;
      end
      if (state == S_ACC) begin
        acc       <= acc_sum;
        round_idx <= next_idx;
        if (next_idx == LAST_IDX) begin
          all_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pergate_am_fj_driver.sv
// Bench for pergate_am_fj_driver: hand-built round table, control corner cases,
// then random gates checked against an arithmetic accumulation model.
module tb_pergate_am_fj_driver;
  import pergate_am_fj_driver_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned IB = $clog2(NR + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic           go;
  logic [NR-1:0]  gate_id;
  logic           busy;
  logic           round_done;
  logic           all_done;
  logic [IB-1:0]  round_idx;
  fe_t [2:0]      acc;

  pergate_am_fj_driver_if uif ();

  pergate_am_fj_driver #(.NROUNDS(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .gate_id    (gate_id),
    .go         (go),
    .busy       (busy),
    .round_done (round_done),
    .all_done   (all_done),
    .round_idx  (round_idx),
    .acc        (acc),
    .unit       (uif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            clr;
    logic [NR-1:0] gid;
    fe_t           f0, f1, f2;
    int            am_lat, fj_lat;
    bit            go_busy;
    bit            e_bit, e_restart;
    fe_t           e0, e1, e2;
    int            e_idx;
    bit            e_done;
  } vec_t;

  vec_t tbl[6];

  // Reference model: plain integer accumulation, one entry per completed round.
  int     m_idx;
  longint m_acc[3];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("en_exclusive", longint'(uif.en_am & uif.en_fj), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_round_done"}, round_done, 0);
    chk({tag, "_all_done"}, all_done, 0);
    chk({tag, "_round_idx"}, round_idx, 0);
    chk({tag, "_acc0"}, acc[0], 0);
    chk({tag, "_acc1"}, acc[1], 0);
    chk({tag, "_acc2"}, acc[2], 0);
    chk({tag, "_en_am"}, uif.en_am, 0);
    chk({tag, "_restart"}, uif.restart, 0);
    chk({tag, "_gate_id_bit"}, uif.gate_id_bit, 0);
    chk({tag, "_en_fj"}, uif.en_fj, 0);
  endtask

  function automatic vec_t mk(input bit clr, input logic [NR-1:0] gid,
                              input fe_t f0, input fe_t f1, input fe_t f2,
                              input int am_lat, input int fj_lat, input bit go_busy,
                              input bit e_bit, input bit e_restart,
                              input fe_t e0, input fe_t e1, input fe_t e2,
                              input int e_idx, input bit e_done);
    vec_t v;
    v.clr = clr; v.gid = gid; v.f0 = f0; v.f1 = f1; v.f2 = f2;
    v.am_lat = am_lat; v.fj_lat = fj_lat; v.go_busy = go_busy;
    v.e_bit = e_bit; v.e_restart = e_restart;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e_idx = e_idx; v.e_done = e_done;
    return v;
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  // One full round against an idle driver; en_am expected the cycle after go,
  // en_fj the cycle after ready_pulse_am, results two cycles after ready_fj.
  task automatic do_round(input vec_t v);
    gate_id = v.gid;
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("am_issue_en_am", uif.en_am, 1);
    chk("am_issue_restart", uif.restart, longint'(v.e_restart));
    chk("am_issue_gate_bit", uif.gate_id_bit, longint'(v.e_bit));
    chk("am_issue_busy", busy, 1);
    uif.ready_pulse_am = 1'b0;
    cyc();
    chk("am_wait_en_am", uif.en_am, 0);
    for (int i = 0; i < v.am_lat; i++) begin
      go = v.go_busy;
      cyc();
      go = 1'b0;
      chk("am_wait_en_am", uif.en_am, 0);
      chk("am_wait_en_fj", uif.en_fj, 0);
    end
    uif.ready_pulse_am = 1'b1;
    cyc();
    uif.ready_pulse_am = 1'b0;
    chk("fj_issue_en_fj", uif.en_fj, 1);
    chk("fj_issue_en_am", uif.en_am, 0);
    cyc();
    chk("fj_wait_en_fj", uif.en_fj, 0);
    for (int i = 0; i < v.fj_lat; i++) begin
      go = v.go_busy;
      cyc();
      go = 1'b0;
      chk("fj_wait_round_done", round_done, 0);
    end
    uif.fj[0] = v.f0;
    uif.fj[1] = v.f1;
    uif.fj[2] = v.f2;
    uif.ready_fj = 1'b1;
    cyc();
    uif.ready_fj = 1'b0;
    for (int k = 0; k < 3; k++) uif.fj[k] = fe_t'($urandom);
    chk("acc_stage_round_done", round_done, 0);
    cyc();
    chk("round_done_pulse", round_done, 1);
    chk("acc0", acc[0], v.e0);
    chk("acc1", acc[1], v.e1);
    chk("acc2", acc[2], v.e2);
    chk("round_idx", round_idx, v.e_idx);
    chk("all_done", all_done, longint'(v.e_done));
    chk("busy_after_round", busy, 0);
    cyc();
    chk("round_done_single", round_done, 0);
  endtask

  function automatic vec_t model_round(input logic [NR-1:0] gid, input fe_t f0,
                                       input fe_t f1, input fe_t f2,
                                       input int am_lat, input int fj_lat, input bit go_busy);
    vec_t   v;
    longint f[3];
    f[0] = f0; f[1] = f1; f[2] = f2;
    v = mk(1'b0, gid, f0, f1, f2, am_lat, fj_lat, go_busy,
           ((gid >> m_idx) & 1) != 0, m_idx == 0, '0, '0, '0, 0, 1'b0);
    for (int k = 0; k < 3; k++) m_acc[k] = (m_acc[k] + f[k]) % longint'(F_Q);
    m_idx++;
    v.e0 = fe_t'(m_acc[0]);
    v.e1 = fe_t'(m_acc[1]);
    v.e2 = fe_t'(m_acc[2]);
    v.e_idx = m_idx;
    v.e_done = (m_idx == NR);
    return v;
  endfunction

  initial begin
    fe_t qm1;
    qm1 = F_Q - fe_t'(1);
    rst = 1'b1; clear = 1'b0; go = 1'b0; gate_id = '0;
    uif.ready_pulse_am = 1'b0; uif.ready_fj = 1'b0; uif.fj = '0;

    //          clr  gid     f0   f1   f2   am fj gb  bit rs  e0   e1   e2   idx done
    tbl[0] = mk(1'b0, 3'b101, 1,   2,   3,   0, 0, 0, 1, 1, 1,   2,   3,   1, 0);
    tbl[1] = mk(1'b0, 3'b101, 1,   2,   3,   2, 1, 1, 0, 0, 2,   4,   6,   2, 0);
    tbl[2] = mk(1'b0, 3'b101, 1,   2,   3,   1, 3, 0, 1, 0, 3,   6,   9,   3, 1);
    tbl[3] = mk(1'b1, 3'b010, qm1, qm1, 0,   1, 0, 0, 0, 1, qm1, qm1, 0,   1, 0);
    tbl[4] = mk(1'b0, 3'b010, 2,   1,   qm1, 0, 2, 1, 1, 0, 1,   0,   qm1, 2, 0);
    tbl[5] = mk(1'b0, 3'b010, qm1, 5,   1,   0, 0, 0, 0, 0, 0,   5,   0,   3, 1);

    cyc();
    cyc();
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc();
    chk_reset_vals("post_reset");

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].clr) do_clear();
      do_round(tbl[i]);
    end

    // go while all_done is ignored
    go = 1'b1;
    cyc();
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("done_go_en_am", uif.en_am, 0);
      chk("done_go_busy", busy, 0);
      chk("done_go_round_idx", round_idx, 3);
      chk("done_go_all_done", all_done, 1);
      cyc();
    end

    // clear during S_FJ_WAIT after one accumulated round
    do_clear();
    do_round(mk(1'b0, 3'b111, 9, 8, 7, 0, 0, 0, 1, 1, 9, 8, 7, 1, 0));
    gate_id = 3'b111;
    go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    uif.ready_pulse_am = 1'b1;
    cyc();
    uif.ready_pulse_am = 1'b0;
    chk("clr_pre_en_fj", uif.en_fj, 1);
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_en_fj", uif.en_fj, 0);
    chk("clr_round_idx", round_idx, 0);
    chk("clr_acc0", acc[0], 0);
    chk("clr_acc1", acc[1], 0);
    chk("clr_acc2", acc[2], 0);
    uif.fj[0] = 11; uif.fj[1] = 12; uif.fj[2] = 13;
    uif.ready_fj = 1'b1;
    cyc();
    uif.ready_fj = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("clr_stray_ready_round_done", round_done, 0);
    chk("clr_stray_ready_acc0", acc[0], 0);
    do_round(mk(1'b0, 3'b001, 4, 5, 6, 1, 1, 0, 1, 1, 4, 5, 6, 1, 0));

    // rst while the unit stalls in S_AM_WAIT
    gate_id = 3'b011;
    go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    cyc();
    chk("rst_pre_busy", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset_vals("mid_rst");
    for (int i = 0; i < 8; i++) cyc();

    // randomized gates against the model
    for (int g = 0; g < 8; g++) begin
      logic [NR-1:0] gid;
      do_clear();
      m_idx = 0;
      for (int k = 0; k < 3; k++) m_acc[k] = 0;
      gid = NR'($urandom);
      for (int r = 0; r < NR; r++) begin
        vec_t v;
        v = model_round(gid,
                        fe_t'($urandom_range(F_Q - 1)),
                        fe_t'($urandom_range(F_Q - 1)),
                        fe_t'($urandom_range(F_Q - 1)),
                        int'($urandom_range(3)), int'($urandom_range(3)),
                        bit'($urandom_range(1)));
        do_round(v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
